// File: rtl/lane_serializer_4to1_if.sv
// Word-in / byte-out bundle for lane_serializer_4to1.
// master = upstream word source plus downstream byte sink; slave = the serializer.
interface lane_serializer_4to1_if;
    logic       word_valid;
    logic       word_ready;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] in3;
    logic [3:0] valid_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_out;
    logic       sow_out;

    modport master (
        output word_valid, in0, in1, in2, in3, valid_in,
        input  word_ready, data_out, valid_out, lane_out, sow_out
    );

    modport slave (
        input  word_valid, in0, in1, in2, in3, valid_in,
        output word_ready, data_out, valid_out, lane_out, sow_out
    );
endinterface

// File: rtl/lane_serializer_4to1.sv
// Two-entry word FIFO feeding a 4:1 byte-lane serializer (lane 0 first, IDLE_SYM when empty).
// Optional macro LANE_SER_SKIP_INVALID_EN skips masked-off lanes instead of spending a cycle on each.
module lane_serializer_4to1 #(
    parameter logic [7:0] IDLE_SYM = 8'h7C
) (
    input  logic                         clk4f,
    input  logic                         reset,
    lane_serializer_4to1_if.slave        bus
);
    // Entry layout: {mask[3:0], lane3, lane2, lane1, lane0}
    logic [35:0] mem_q [2];
    logic [35:0] mem_d [2];
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic [1:0]  lane_out_q, lane_out_d;
    logic        sow_out_q, sow_out_d;

    logic        word_ready;
    logic        push, pop;
    logic [35:0] head;
    logic [3:0]  head_mask;
    logic [7:0]  head_byte [4];

`ifdef LANE_SER_SKIP_INVALID_EN
    logic        cur_found, next_found;
    logic [1:0]  cur_lane, next_lane;
    logic        earlier_set;
`endif

    assign word_ready     = !reset && (count_q != 2'd2);
    assign bus.word_ready = word_ready;
    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.lane_out   = lane_out_q;
    assign bus.sow_out    = sow_out_q;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        head_mask = head[35:32];
        for (int i = 0; i < 4; i++) begin
            head_byte[i] = head[8*i +: 8];
        end

        push        = bus.word_valid && word_ready;
        pop         = 1'b0;
        lane_d      = lane_q;
        data_out_d  = IDLE_SYM;
        valid_out_d = 1'b0;
        lane_out_d  = 2'd0;
        sow_out_d   = 1'b0;

`ifdef LANE_SER_SKIP_INVALID_EN
        cur_found   = 1'b0;
        cur_lane    = 2'd0;
        next_found  = 1'b0;
        next_lane   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!cur_found && head_mask[i] && (2'(i) >= lane_q)) begin
                cur_found = 1'b1;
                cur_lane  = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (cur_found && !next_found && head_mask[i] && (2'(i) > cur_lane)) begin
                next_found = 1'b1;
                next_lane  = 2'(i);
            end
        end
        earlier_set = |(head_mask & ((4'd1 << cur_lane) - 4'd1));

        if (count_q != 2'd0) begin
            if (!cur_found) begin
                // Nothing left to issue (all-zero mask): retire the word in one idle cycle.
                pop    = 1'b1;
                lane_d = 2'd0;
            end else begin
                data_out_d  = head_byte[cur_lane];
                valid_out_d = 1'b1;
                lane_out_d  = cur_lane;
                sow_out_d   = !earlier_set;
                pop         = !next_found;
                lane_d      = next_found ? next_lane : 2'd0;
            end
        end
`else
        if (count_q != 2'd0) begin
            data_out_d  = head_mask[lane_q] ? head_byte[lane_q] : IDLE_SYM;
            valid_out_d = head_mask[lane_q];
            lane_out_d  = lane_q;
            sow_out_d   = (lane_q == 2'd0);
            pop         = (lane_q == 2'd3);
            lane_d      = lane_q + 2'd1;
        end
`endif

        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        if (push) begin
            mem_d[wr_ptr_q] = {bus.valid_in, bus.in3, bus.in2, bus.in1, bus.in0};
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk4f or posedge reset) begin
        if (reset) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            lane_q      <= 2'd0;
            data_out_q  <= IDLE_SYM;
            valid_out_q <= 1'b0;
            lane_out_q  <= 2'd0;
            sow_out_q   <= 1'b0;
        end else begin
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lane_q      <= lane_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            lane_out_q  <= lane_out_d;
            sow_out_q   <= sow_out_d;
        end
    end
endmodule

// File: tb/tb_lane_serializer_4to1.sv
// Randomized self-checking bench for lane_serializer_4to1 (default build, fixed 4 cycles per word).
// Reference: a queue of expected output bytes; each accepted word appends its four lane slots.
module tb_lane_serializer_4to1;
    localparam logic [7:0] IDLE = 8'h7C;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [1:0] l;
        logic       s;
    } exp_t;

    logic clk4f = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic acc;
    exp_t exp_q[$];

    lane_serializer_4to1_if bus ();

    lane_serializer_4to1 #(.IDLE_SYM(IDLE)) dut (
        .clk4f (clk4f),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk4f = ~clk4f;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, ".data_out"},  32'(bus.data_out),  32'(IDLE));
        check_val({tag, ".valid_out"}, 32'(bus.valid_out), 32'd0);
        check_val({tag, ".lane_out"},  32'(bus.lane_out),  32'd0);
        check_val({tag, ".sow_out"},   32'(bus.sow_out),   32'd0);
    endtask

    // Offer (or withhold) a word for one clock and check everything the edge produces.
    task automatic cycle(input logic wv, input logic [31:0] w, input logic [3:0] m);
        logic exp_ready;
        exp_t e;
        @(negedge clk4f);
        bus.word_valid = wv;
        bus.in0        = w[7:0];
        bus.in1        = w[15:8];
        bus.in2        = w[23:16];
        bus.in3        = w[31:24];
        bus.valid_in   = m;
        #1;
        // Words held = ceil(bytes still to issue / 4); ready while fewer than two.
        exp_ready = (exp_q.size() <= 4);
        check_val("word_ready", 32'(bus.word_ready), 32'(exp_ready));
        acc = wv && exp_ready;
        @(posedge clk4f);
        #1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{d: IDLE, v: 1'b0, l: 2'd0, s: 1'b0};
        check_val("data_out",  32'(bus.data_out),  32'(e.d));
        check_val("valid_out", 32'(bus.valid_out), 32'(e.v));
        check_val("lane_out",  32'(bus.lane_out),  32'(e.l));
        check_val("sow_out",   32'(bus.sow_out),   32'(e.s));
        $display("t=%0t wv=%0b acc=%0b data=%02h v=%0b lane=%0d sow=%0b", $time, wv, acc,
                 bus.data_out, bus.valid_out, bus.lane_out, bus.sow_out);
        if (acc) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back('{d: m[i] ? w[8*i +: 8] : IDLE, v: m[i], l: 2'(i), s: (i == 0)});
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk4f);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        check_val("rst_async.word_ready", 32'(bus.word_ready), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk4f);
        #1;
        check_idle_outputs("rst_hold");
        check_val("rst_hold.word_ready", 32'(bus.word_ready), 32'd0);
        @(negedge clk4f);
        reset          = 1'b0;
        bus.word_valid = 1'b0;
        #1;
        check_val("rst_release.word_ready", 32'(bus.word_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] words [6];
        int          idx;
        int          guard;

        bus.word_valid = 1'b0;
        bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
        bus.valid_in = '0;

        // Reset / idle
        do_reset();
        repeat (10) cycle(1'b0, 32'h0, 4'h0);

        // Single word FF/EE/DD/CC
        cycle(1'b1, 32'hCCDDEEFF, 4'b1111);
        repeat (6) cycle(1'b0, 32'h0, 4'h0);

        // Back-to-back with continuous offers; re-offer until accepted
        words = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233, 32'hDEADBEEF, 32'h0BADF00D};
        idx   = 0;
        guard = 0;
        while (idx < 6 && guard < 100) begin
            cycle(1'b1, words[idx], 4'b1111);
            if (acc) idx++;
            guard++;
        end
        check_val("b2b.all_accepted", 32'(idx), 32'd6);
        repeat (12) cycle(1'b0, 32'h0, 4'h0);

        // Masked lanes
        cycle(1'b1, 32'h8899AABB, 4'b0000);
        cycle(1'b1, 32'hCCDDEEFF, 4'b0101);
        repeat (10) cycle(1'b0, 32'h0, 4'h0);

        // Reset mid-word with a second word queued (EE issues on the third edge)
        cycle(1'b1, 32'hCCDDEEFF, 4'b1111);
        cycle(1'b1, 32'h8899AABB, 4'b1111);
        cycle(1'b0, 32'h0, 4'h0);
        do_reset();
        repeat (10) cycle(1'b0, 32'h0, 4'h0);

        // Push on the same edge the head issues lane 3
        cycle(1'b1, 32'h44332211, 4'b1111);
        repeat (3) cycle(1'b0, 32'h0, 4'h0);
        cycle(1'b1, 32'h88776655, 4'b1011);
        repeat (6) cycle(1'b0, 32'h0, 4'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, 4'($urandom));
        end
        repeat (10) cycle(1'b0, 32'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lane_serializer_4to1.md
# lane_serializer_4to1

- Byte-lane serializer directly downstream of the recirculation-idle stage.
- Accepts one 4-lane word per handshake: four 8-bit lanes plus a per-lane valid mask.
- Buffers up to two words and emits them one byte per `clk4f` cycle in lane order 0→3.
- Output is a single byte stream with a valid flag, feeding the parallel-to-serial converter; when no data is available it emits the IDLE symbol.

## Interface
Parameters:
- `IDLE_SYM`, default 8'h7C: byte driven on `data_out` when no valid byte is issued.

Ports:
- `clk4f` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `word_valid` in 1: upstream offers `in0..in3` and `valid_in` this cycle.
- `word_ready` out 1: block accepts the word at this edge if `word_valid` is also high.
- `in0`, `in1`, `in2`, `in3` in 8 each: lane bytes 0..3.
- `valid_in` in 4: bit i qualifies lane i.
- `data_out` out 8: serialized byte, registered.
- `valid_out` out 1: `data_out` carries a valid lane byte, registered.
- `lane_out` out 2: source lane index of `data_out`, registered.
- `sow_out` out 1: start of word; high with the first byte issued from a word, registered.

## Operation
Word FIFO:
- Two entries, 36 bits each (`{valid_in, in3, in2, in1, in0}`), with a 2-bit count (0..2) and 1-bit read/write pointers that wrap 1→0.
- `word_ready = !reset && (count != 2)`. There is no pass-through: when full, `word_ready` stays low even in a cycle that pops.
- Push happens on `word_valid && word_ready`.
- Simultaneous push and pop leaves count unchanged and advances both pointers.

Lane counter `lane` (2 bits) tracks the byte being issued from the head word:
- If FIFO is non-empty at an edge:
  - Register the head byte selected by `lane`.
  - Set `valid_out` to the head mask bit for that lane.
  - Set `lane_out` to `lane`.
  - Set `sow_out` to 1 when `lane == 0`.
- If `lane == 3`, pop the head and set `lane` to 0; otherwise increment `lane`.
- If FIFO is empty at an edge: `data_out <= IDLE_SYM`, `valid_out <= 0`, `lane_out <= 0`, `sow_out <= 0`, `lane` holds.
- A lane whose mask bit is 0 still consumes its cycle and drives `IDLE_SYM` with `valid_out = 0` (default build; see Configuration).

Reset:
- Reset mid-word discards both FIFO entries and any partially issued word. No residue appears after release.

## Timing
- Reset values:
  - `data_out = IDLE_SYM`, `valid_out = 0`, `lane_out = 0`, `sow_out = 0`, `word_ready = 0`.
  - Internal: count 0, pointers 0, `lane` 0.
- First edge after reset release: `word_ready = 1`.
- Latency: a word accepted at edge N into an empty FIFO drives lane 0 after edge N+1, then lanes 1, 2, 3 after edges N+2, N+3, N+4.
- Pop occurs at edge N+4.
- Throughput: one word per 4 cycles. With continuous offers, `word_ready` deasserts once 2 words are held, then toggles as pops free entries.
- A gapless stream requires a second word to be present by edge N+4. There are no idle cycles between back-to-back words.

## Configuration
Macro `LANE_SER_SKIP_INVALID_EN`:
- Defined:
  - Lanes with mask bit 0 are skipped and consume no output cycle. `lane` jumps to the next set mask bit.
  - A word whose remaining mask is empty is popped in the cycle its last valid lane issues.
  - An all-zero-mask word is popped in one cycle with IDLE output and `sow_out = 0`.
  - `sow_out` marks the first valid byte issued from the word.
- Undefined: fixed 4-cycle-per-word behaviour as described in Operation.

## Test plan
- **Reset/idle:**
  - Stimulus: assert `reset` asynchronously mid-cycle; release; keep `word_valid = 0` for 10 cycles.
  - Response: `data_out = 8'h7C`, `valid_out = 0`, `word_ready = 0` while in reset, then 1 on the first edge after release.
- **Single word:**
  - Stimulus: push FF/EE/DD/CC with mask 4'b1111 at edge N.
  - Response: FF, EE, DD, CC on edges N+1..N+4; `valid_out = 1`; `lane_out` 0..3; `sow_out` only with FF; then 7C.
- **Back-to-back and full:**
  - Stimulus: continuous `word_valid` with words FF/EE/DD/CC then BB/AA/99/88 then 77…
  - Response: `word_ready` falls after 2 words are held; output stream is unbroken with 4-cycle spacing; no word is lost or duplicated.
- **Masked lanes:**
  - Stimulus: push BB/AA/99/88 with mask 4'b0000, then FF/EE/DD/CC with mask 4'b0101.
  - Response (default build): 8 cycles of output; `valid_out` pattern 0000 then 1010 in lane order (FF and DD valid); invalid slots show 7C.
  - Response (`LANE_SER_SKIP_INVALID_EN`): 1 idle cycle for the first word, then FF (lane 0) and DD (lane 2) with `sow_out` on FF.
- **Reset mid-word:**
  - Stimulus: assert `reset` after EE issues, with a second word queued.
  - Response: outputs go to reset values immediately; after release with no pushes, only 7C is driven; count is 0.
- **Simultaneous push/pop:**
  - Stimulus: one word held; push at the same edge the head issues lane 3.
  - Response: count stays 1; the next word's lane 0 follows on the next edge.
